// File: rtl/genius_pkg.sv
// Shared types and constants for the genius input checker.
// Holds the checker state enum, the 2-bit colour codes and the one-hot
// button/ROM colour patterns. Imported by onehot_enc and genius_input_checker.
package genius_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_REL,
    WAIT_PRESS
  } state_t;

  // Encoded colour codes driven on cor
  localparam logic [1:0] COR_VERDE    = 2'b00;
  localparam logic [1:0] COR_VERMELHO = 2'b01;
  localparam logic [1:0] COR_AZUL     = 2'b10;
  localparam logic [1:0] COR_AMARELO  = 2'b11;

  // One-hot patterns as seen on the buttons and from the sequence ROM
  localparam logic [3:0] OH_VERDE    = 4'b0001;
  localparam logic [3:0] OH_VERMELHO = 4'b0010;
  localparam logic [3:0] OH_AZUL     = 4'b0100;
  localparam logic [3:0] OH_AMARELO  = 4'b1000;

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to colour-code encoder.
// Ports:
//   onehot  in  NBTN  button pattern (one-hot when exactly one button is pressed)
//   code    out 2     colour code of the pattern; COR_VERDE when not one-hot
//   valid   out 1     exactly one bit of onehot is set
// The code mapping is defined for NBTN = 4.
module onehot_enc
  import genius_pkg::*;
#(
  parameter int unsigned NBTN = 4
) (
  input  logic [NBTN-1:0] onehot,
  output logic [1:0]      code,
  output logic            valid
);

  logic [3:0] oh4;

  assign oh4   = 4'(onehot);
  assign valid = $onehot(onehot);

  always_comb begin
    code = COR_VERDE;
    case (oh4)
      OH_VERDE:    code = COR_VERDE;
      OH_VERMELHO: code = COR_VERMELHO;
      OH_AZUL:     code = COR_AZUL;
      OH_AMARELO:  code = COR_AMARELO;
      default:     code = COR_VERDE;
    endcase
  end

endmodule

// File: rtl/genius_input_checker.sv
// Player input checker for the genius game.
// Steps the sequence ROM address, compares each button press against the
// ROM's expected one-hot colour and reports round success or failure.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle pulse, begins a round (ignored while busy)
//   round_len  in   index of the last step of the round, sampled on start
//   botoes     in   debounced button levels, one-hot colour
//   esperado   in   expected one-hot colour from the ROM at address
//   address    out  current step index to the sequence ROM
//   cor        out  colour code of the last valid press
//   busy       out  round in progress
//   acerto     out  one-cycle pulse, round entered correctly
//   erro       out  one-cycle pulse, wrong colour, multi-press or timeout
//   timeout    out  one-cycle pulse with erro when the cause is a timeout
// Optional: define GENIUS_TIMEOUT_EN to build the press timeout counter
// (TIMEOUT_CYC cycles). Without it, timeout is tied low and presses are
// awaited indefinitely.
module genius_input_checker
  import genius_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NBTN        = 4,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] round_len,
  input  logic [NBTN-1:0]   botoes,
  input  logic [NBTN-1:0]   esperado,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        cor,
  output logic              busy,
  output logic              acerto,
  output logic              erro,
  output logic              timeout
);

  state_t            state_q, state_d;
  logic [NBTN-1:0]   btn_q;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [1:0]        cor_q, cor_d;
  logic              acerto_q, acerto_d;
  logic              erro_q, erro_d;
  logic              timeout_d;
  logic              tmo_hit;
  logic [1:0]        btn_code;
  logic              btn_valid;

  onehot_enc #(
    .NBTN (NBTN)
  ) u_enc (
    .onehot (btn_q),
    .code   (btn_code),
    .valid  (btn_valid)
  );

`ifdef GENIUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Held at zero outside WAIT_PRESS, so every entry starts a fresh count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == WAIT_PRESS) ? cnt_q + CNT_W'(1) : '0;
      timeout_q <= timeout_d;
    end
  end

  assign tmo_hit = (state_q == WAIT_PRESS) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    address_d  = address_q;
    cor_d      = cor_q;
    acerto_d   = 1'b0;
    erro_d     = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        address_d = '0;
        if (start) begin
          last_idx_d = round_len;
          state_d    = WAIT_REL;
        end
      end
      // A button still held from the previous step (or from before start)
      // must be released before the next press is accepted.
      WAIT_REL: begin
        if (btn_q == '0) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (btn_q != '0) begin
          if (!btn_valid) begin
            erro_d    = 1'b1;
            address_d = '0;
            state_d   = IDLE;
          end else begin
            cor_d = btn_code;
            if (btn_q != esperado) begin
              erro_d    = 1'b1;
              address_d = '0;
              state_d   = IDLE;
            end else if (address_q == last_idx_q) begin
              acerto_d  = 1'b1;
              address_d = '0;
              state_d   = IDLE;
            end else begin
              address_d = address_q + ADDR_W'(1);
              state_d   = WAIT_REL;
            end
          end
        end else if (tmo_hit) begin
          // A press seen on the same cycle wins over the timeout
          erro_d    = 1'b1;
          timeout_d = 1'b1;
          address_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        address_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      btn_q      <= '0;
      last_idx_q <= '0;
      address_q  <= '0;
      cor_q      <= COR_VERDE;
      acerto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= botoes;
      last_idx_q <= last_idx_d;
      address_q  <= address_d;
      cor_q      <= cor_d;
      acerto_q   <= acerto_d;
      erro_q     <= erro_d;
    end
  end

  // busy drops on the same edge that raises acerto/erro
  assign busy    = (state_q != IDLE);
  assign address = address_q;
  assign cor     = cor_q;
  assign acerto  = acerto_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_genius_input_checker.sv
module tb_genius_input_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] round_len;
  logic [3:0] botoes;
  logic [3:0] esperado;
  logic [3:0] address;
  logic [1:0] cor;
  logic       busy, acerto, erro, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Sequence ROM model: 0001,0100,0001,1000 repeating every 4 steps
  function automatic logic [3:0] rom_f(input logic [3:0] a);
    case (a[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  assign esperado = rom_f(address);

  genius_input_checker #(
    .ADDR_W      (4),
    .NBTN        (4),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .round_len (round_len),
    .botoes    (botoes),
    .esperado  (esperado),
    .address   (address),
    .cor       (cor),
    .busy      (busy),
    .acerto    (acerto),
    .erro      (erro),
    .timeout   (timeout)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] rlen;
    logic [3:0] btn;
    logic [3:0] addr;
    logic [1:0] cor;
    logic       busy;
    logic       acerto;
    logic       erro;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [3:0] rl, input logic [3:0] b,
                     input logic [3:0] ea, input logic [1:0] ec, input logic eb,
                     input logic eac, input logic eer);
    vec_t v;
    v.rst = r; v.start = s; v.rlen = rl; v.btn = b;
    v.addr = ea; v.cor = ec; v.busy = eb; v.acerto = eac; v.erro = eer;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample just after the next rising edge
  task automatic cyc(input logic s, input logic [3:0] rl, input logic [3:0] b);
    @(negedge clk);
    start = s; round_len = rl; botoes = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; round_len = '0; botoes = '0;
    #12;
    chk("reset.addr", 32'(address), 0);
    chk("reset.cor", 32'(cor), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.acerto", 32'(acerto), 0);
    chk("reset.erro", 32'(erro), 0);
    chk("reset.timeout", 32'(timeout), 0);

    //   rst start rlen  btn      addr cor  busy acerto erro
    // Full correct round of 4 steps
    add(0, 1, 3, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0100, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 2, 2'b10, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 2, 2'b10, 1, 0, 0);
    add(0, 0, 0, 4'b0001, 2, 2'b10, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 3, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 3, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b1000, 3, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b11, 0, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b11, 0, 0, 0);
    // Wrong colour on step 1
    add(0, 1, 3, 4'b0000, 0, 2'b11, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b11, 1, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 2'b11, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0010, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b01, 0, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 2'b01, 0, 0, 0);
    // Multi-button press after reset: erro, cor stays at reset value
    add(1, 0, 0, 4'b0000, 0, 2'b00, 0, 0, 0);
    add(0, 1, 0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0101, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 0, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 0, 0, 0);
    // Button held across start, round_len = 0
    add(0, 0, 0, 4'b0001, 0, 2'b00, 0, 0, 0);
    add(0, 1, 0, 4'b0001, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 0, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b00, 0, 0, 0);
    // start while busy is ignored; round_len stays 1
    add(0, 1, 1, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 1, 0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add(0, 1, 0, 4'b0001, 0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0100, 1, 2'b00, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b10, 0, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 2'b10, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start;
      round_len = vecs[i].rlen; botoes = vecs[i].btn;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.addr", i), 32'(address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d.cor", i), 32'(cor), 32'(vecs[i].cor));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d.acerto", i), 32'(acerto), 32'(vecs[i].acerto));
      chk($sformatf("vec%0d.erro", i), 32'(erro), 32'(vecs[i].erro));
      chk($sformatf("vec%0d.timeout", i), 32'(timeout), 0);
    end

    // Longest round: round_len = 15 ends at address 15 with acerto
    cyc(1, 15, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("long%0d.addr_before", i), 32'(address), 32'(i));
      cyc(0, 0, rom_f(4'(i)));
      cyc(0, 0, 0);
      if (i < 15) begin
        chk($sformatf("long%0d.addr_after", i), 32'(address), 32'(i + 1));
        chk($sformatf("long%0d.acerto", i), 32'(acerto), 0);
        cyc(0, 0, 0);
      end else begin
        chk("long.acerto", 32'(acerto), 1);
        chk("long.busy", 32'(busy), 0);
        chk("long.addr", 32'(address), 0);
        chk("long.cor", 32'(cor), 32'(2'b11));
      end
    end

    // Reset mid-round at step 2 acts immediately, emits no pulse
    cyc(1, 3, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 4'b0001); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 4'b0100); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("midrst.addr_before", 32'(address), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.addr", 32'(address), 0);
    chk("midrst.busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    chk("midrst.acerto", 32'(acerto), 0);
    chk("midrst.erro", 32'(erro), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 4'b0001);
    cyc(0, 0, 0);
    chk("postrst.acerto", 32'(acerto), 1);
    cyc(0, 0, 0);
    chk("postrst.acerto_drop", 32'(acerto), 0);

`ifdef GENIUS_TIMEOUT_EN
    // No press: erro+timeout 20 cycles after entering WAIT_PRESS
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    bad = 0;
    for (int k = 0; k < 19; k++) begin
      cyc(0, 0, 0);
      if (erro || timeout || !busy) bad++;
    end
    chk("tmo.early", 32'(bad), 0);
    cyc(0, 0, 0);
    chk("tmo.erro", 32'(erro), 1);
    chk("tmo.timeout", 32'(timeout), 1);
    chk("tmo.busy", 32'(busy), 0);
    cyc(0, 0, 0);
    chk("tmo.erro_drop", 32'(erro), 0);
    chk("tmo.timeout_drop", 32'(timeout), 0);
`else
    // No timeout built: WAIT_PRESS waits indefinitely
    cyc(1, 0, 0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 0);
      if (erro || timeout || !busy) bad++;
    end
    chk("notmo.waiting", 32'(bad), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/genius_input_checker.md
Name: genius_input_checker

Overview:
- Player-side counterpart of the sequence ROM. The ROM turns a step index into a one-hot colour; this block turns one-hot button presses back into colour codes.
- It steps the ROM address itself and compares each press against the expected colour.
- Reports round success or failure to the game FSM.
- Sits between the button pads and the game control FSM. Its address output drives the sequence ROM; the ROM's one-hot output returns on `esperado`.

Parameters:
- ADDR_W, 4, width of the sequence address and round length.
- NBTN, 4, number of colour buttons. Fixed one-hot width; the encoding is defined for 4 only.
- TIMEOUT_CYC, 50_000_000, press timeout in clk cycles. Used only with GENIUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins the input phase of a round.
- round_len  in  ADDR_W  index of the last step in this round (0 means 1 step). Sampled on start.
- botoes  in  NBTN  debounced, synchronous button levels, one-hot colour.
- esperado  in  NBTN  one-hot expected colour from the sequence ROM at `address`.
- address  out  ADDR_W  current step index driven to the sequence ROM.
- cor  out  2  encoded colour of the last valid press: 0001->00, 0010->01, 0100->10, 1000->11.
- busy  out  1  high while a round is in progress.
- acerto  out  1  one-cycle pulse: whole round entered correctly.
- erro  out  1  one-cycle pulse: wrong colour, multi-button press, or timeout.
- timeout  out  1  one-cycle pulse coincident with erro when the cause is a timeout.

Behaviour:
- Reset (async, rst=1): state=IDLE; address=0, cor=00, busy=0, acerto=0, erro=0, timeout=0; btn_q=0; last_idx=0.
- botoes is registered every cycle into btn_q. All decisions use btn_q and `esperado` (combinational from the ROM, valid the same cycle as address).
- **IDLE**
  - busy=0, address=0.
  - start=1: last_idx<=round_len, busy<=1, go WAIT_REL.
- **WAIT_REL**
  - btn_q==0: go WAIT_PRESS. A held button never counts twice.
- **WAIT_PRESS**
  - On the first cycle with btn_q!=0, decide in that same edge.
  - btn_q not one-hot (2+ bits set): erro=1 next cycle, go IDLE.
  - btn_q one-hot: cor<=enc(btn_q).
    - If btn_q!=esperado: erro=1, go IDLE.
    - If match and address==last_idx: acerto=1, go IDLE.
    - If match otherwise: address<=address+1, go WAIT_REL.
- Latency: button edge at botoes -> btn_q +1 cycle -> acerto/erro/cor/address update +1 cycle, i.e. 2 clk from the botoes change.
- Pulses acerto/erro/timeout are high exactly one cycle. busy falls in the same cycle they rise.
- Boundaries:
  - start while busy=1 is ignored. round_len is not re-sampled.
  - round_len=0 completes on the first correct press.
  - round_len=15 ends at address 15 with acerto. address never wraps.
  - A press already held at start is not a press: it must be released first (WAIT_REL).
  - rst mid-round aborts immediately to the reset values. No pulse is emitted.
  - cor holds its value across rounds until the next valid press.

Optional Feature:
- GENIUS_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_PRESS and increments each cycle there.
  - On reaching TIMEOUT_CYC-1 with no press: erro=1 and timeout=1 for one cycle, go IDLE.
  - A press on that same cycle takes priority over the timeout.
- Not defined: no counter is built, timeout is tied to 0, and WAIT_PRESS waits indefinitely.

Decomposition:
- genius_pkg holds:
  - the state enum (IDLE, WAIT_REL, WAIT_PRESS);
  - the colour-code constants COR_VERDE=00, COR_VERMELHO=01, COR_AZUL=10, COR_AMARELO=11;
  - the one-hot constants.
- Sub-module onehot_enc: combinational NBTN->2 encoder with a `valid` output (exactly one bit set). Used for cor and the multi-press check.

Test Plan:
- ROM returns 0001,0100,0001,1000 at addresses 0..3. round_len=3, press 0001,0100,0001,1000 each with a release between -> address steps 0,1,2,3; cor 00,10,00,11; single acerto; busy falls.
- Same setup, press 0001 then 0010 -> erro pulse after the second press, acerto never asserted, address back to 0, cor=01.
- Press 0101 at step 0 -> erro, cor unchanged (00 from reset).
- Hold 0001 before start, round_len=0 -> no decision while held. Release, then press 0001 -> acerto.
- Assert rst at step 2 mid-round -> address=0, busy=0 asynchronously, no acerto/erro. A start after rst releases works normally.
- GENIUS_TIMEOUT_EN with TIMEOUT_CYC=20, no press after start -> erro and timeout high for one cycle 20 cycles into WAIT_PRESS.
